// File: rtl/msrv32_regfile_sb.sv
// msrv32 integer register file with same-cycle write bypass and a per-register pending-write scoreboard.
// Optional per-register even parity is enabled by defining MSRV32_RF_PARITY_EN.
module msrv32_regfile_sb #(
  parameter  int XLEN     = 32,
  parameter  int NUM_REGS = 32,
  parameter  int NUM_RD   = 2,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                   ms_riscv32_mp_clk_in,
  input  logic                   ms_riscv32_mp_rst_in,
  input  logic                   wr_en_in,
  input  logic [AW-1:0]          rd_addr_in,
  input  logic [XLEN-1:0]        rd_in,
  input  logic                   iss_en_in,
  input  logic [AW-1:0]          iss_addr_in,
  output logic                   iss_ready_out,
  input  logic                   flush_in,
  input  logic [NUM_RD*AW-1:0]   rs_addr_in,
  output logic [NUM_RD*XLEN-1:0] rs_out,
  output logic [NUM_RD-1:0]      rs_busy_out
`ifdef MSRV32_RF_PARITY_EN
  ,
  input  logic                   par_inject_in,
  output logic [NUM_RD-1:0]      par_err_out
`endif
);

  logic [XLEN-1:0] data_arr [NUM_REGS];
  logic [1:0]      cnt_arr  [NUM_REGS];

  // x0 has no storage: it reads zero and never has a pending write.
  assign data_arr[0] = '0;
  assign cnt_arr[0]  = '0;

`ifdef MSRV32_RF_PARITY_EN
  logic par_arr [NUM_REGS];
  assign par_arr[0] = 1'b0;
`endif

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic [XLEN-1:0] data_reg;
      logic [1:0]      cnt_reg;
      logic [1:0]      cnt_next;
      logic            wb_hit;
      logic            iss_hit;
      logic            inc;
      logic            dec;

      assign wb_hit  = wr_en_in && (rd_addr_in == AW'(gi));
      assign iss_hit = iss_en_in && (iss_addr_in == AW'(gi));
      // A saturated count drops the issue; an idle count ignores a stray writeback.
      assign inc     = iss_hit && (cnt_reg != 2'd3);
      assign dec     = wb_hit && (cnt_reg != 2'd0);

      always_comb begin
        cnt_next = cnt_reg;
        if (flush_in) begin
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + {1'b0, inc} - {1'b0, dec};
        end
      end

      always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
          data_reg <= '0;
          cnt_reg  <= '0;
        end else begin
          if (wb_hit) begin
            data_reg <= rd_in;
          end
          cnt_reg <= cnt_next;
        end
      end

      assign data_arr[gi] = data_reg;
      assign cnt_arr[gi]  = cnt_reg;

`ifdef MSRV32_RF_PARITY_EN
      logic par_reg;

      always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
          par_reg <= 1'b0;
        end else if (wb_hit) begin
          par_reg <= (^rd_in) ^ par_inject_in;
        end
      end

      assign par_arr[gi] = par_reg;
`endif
    end
  endgenerate

  assign iss_ready_out = (iss_addr_in == '0) || (cnt_arr[iss_addr_in] != 2'd3);

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0] addr;
      logic          bypass;
      logic          iss_same;

      assign addr     = rs_addr_in[gi*AW +: AW];
      assign bypass   = wr_en_in && (rd_addr_in == addr) && (addr != '0);
      assign iss_same = iss_en_in && (iss_addr_in == addr);

      assign rs_out[gi*XLEN +: XLEN] = bypass ? rd_in : data_arr[addr];

      // The last outstanding writeback arriving now is bypassed, so decode need not wait.
      assign rs_busy_out[gi] = (cnt_arr[addr] != 2'd0) &&
                               !(bypass && (cnt_arr[addr] == 2'd1) && !iss_same);

`ifdef MSRV32_RF_PARITY_EN
      assign par_err_out[gi] = (addr != '0) && !bypass &&
                               (par_arr[addr] != (^data_arr[addr]));
`endif
    end
  endgenerate

endmodule

// File: tb/tb_msrv32_regfile_sb.sv
// Scoreboard bench for msrv32_regfile_sb: directed scenarios plus random traffic against a reference model.
module tb_msrv32_regfile_sb;
  localparam int XLEN = 32;
  localparam int NR   = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [AW-1:0]     rd_addr;
  logic [XLEN-1:0]   rd_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              iss_ready;
  logic              flush;
  logic [NRD*AW-1:0] rs_addr;
  logic [NRD*XLEN-1:0] rs_out;
  logic [NRD-1:0]    rs_busy;
  logic              inj;
  logic [NRD-1:0]    perr;

  always #5 clk = ~clk;

  msrv32_regfile_sb #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD(NRD)) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .wr_en_in(wr_en),
    .rd_addr_in(rd_addr),
    .rd_in(rd_data),
    .iss_en_in(iss_en),
    .iss_addr_in(iss_addr),
    .iss_ready_out(iss_ready),
    .flush_in(flush),
    .rs_addr_in(rs_addr),
    .rs_out(rs_out),
    .rs_busy_out(rs_busy)
`ifdef MSRV32_RF_PARITY_EN
    ,
    .par_inject_in(inj),
    .par_err_out(perr)
`endif
  );

`ifndef MSRV32_RF_PARITY_EN
  assign perr = '0;
`endif

  // Reference model: architectural contents, number of writes still owed, corrupted-parity flag.
  logic [XLEN-1:0] m_mem [NR];
  int              m_pend [NR];
  bit              m_bad [NR];

  typedef struct {
    int              id;
    logic [XLEN-1:0] d0;
    logic [XLEN-1:0] d1;
    logic            b0;
    logic            b1;
    logic            rdy;
    logic            e0;
    logic            e1;
  } exp_t;

  exp_t sb_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   txn_id   = 0;

  task automatic chk(input string nm, input int id, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s txn %0d: got %h expected %h", nm, id, act, exp);
  endtask

  function automatic void model_clear();
    for (int r = 0; r < NR; r++) begin
      m_mem[r]  = '0;
      m_pend[r] = 0;
      m_bad[r]  = 1'b0;
    end
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wr_en && rd_addr == a) return rd_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    bool_t: begin end
    if (a == 0 || m_pend[a] == 0) return 1'b0;
    if (wr_en && rd_addr == a && m_pend[a] == 1 && !(iss_en && iss_addr == a)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic exp_perr(input logic [AW-1:0] a);
`ifdef MSRV32_RF_PARITY_EN
    if (a == 0 || (wr_en && rd_addr == a)) return 1'b0;
    return m_bad[a];
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_step();
    bit ok_iss;
    bit ok_wb;
    ok_iss = iss_en && iss_addr != 0 && m_pend[iss_addr] < 3;
    ok_wb  = wr_en && rd_addr != 0 && m_pend[rd_addr] > 0;
    if (wr_en && rd_addr != 0) begin
      m_mem[rd_addr] = rd_data;
      m_bad[rd_addr] = inj;
    end
    if (flush) begin
      for (int r = 0; r < NR; r++) m_pend[r] = 0;
    end else begin
      if (ok_iss) m_pend[iss_addr] = m_pend[iss_addr] + 1;
      if (ok_wb)  m_pend[rd_addr]  = m_pend[rd_addr] - 1;
    end
  endfunction

  task automatic drive(input bit r, input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                       input logic ie, input logic [AW-1:0] ia, input logic fl,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic ij);
    exp_t e;
    @(negedge clk);
    rst = r; wr_en = we; rd_addr = wa; rd_data = wd;
    iss_en = ie; iss_addr = ia; flush = fl; rs_addr = {a1, a0}; inj = ij;
    if (r) model_clear();
    e.id  = txn_id++;
    e.d0  = exp_data(a0);
    e.d1  = exp_data(a1);
    e.b0  = exp_busy(a0);
    e.b1  = exp_busy(a1);
    e.rdy = (ia == 0) || (m_pend[ia] < 3);
    e.e0  = exp_perr(a0);
    e.e1  = exp_perr(a1);
    sb_q.push_back(e);
    @(posedge clk);
    if (!r) model_step();
  endtask

  task automatic idle_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    drive(0, 0, 0, 0, 0, 0, 0, a0, a1, 0);
  endtask

  // Monitor: outputs are combinational, so compare once inputs have settled and before the next edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("rs0_data", e.id, rs_out[XLEN-1:0], e.d0);
        chk("rs1_data", e.id, rs_out[2*XLEN-1:XLEN], e.d1);
        chk("rs0_busy", e.id, {31'b0, rs_busy[0]}, {31'b0, e.b0});
        chk("rs1_busy", e.id, {31'b0, rs_busy[1]}, {31'b0, e.b1});
        chk("iss_ready", e.id, {31'b0, iss_ready}, {31'b0, e.rdy});
        chk("par_err", e.id, {30'b0, perr}, {30'b0, e.e1, e.e0});
        $display("txn %0d: rs0=%h rs1=%h busy=%b ready=%b perr=%b", e.id,
                 rs_out[XLEN-1:0], rs_out[2*XLEN-1:XLEN], rs_busy, iss_ready, perr);
      end
    end
  end

  initial begin
    int t;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [AW-1:0] rw;
    logic [AW-1:0] ri;
    rst = 1'b1; wr_en = 0; rd_addr = 0; rd_data = 0; iss_en = 0; iss_addr = 0;
    flush = 0; rs_addr = 0; inj = 0;
    model_clear();

    // Reset state on every address and both ports
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    for (int a = 0; a < NR; a++) drive(0, 0, 0, 0, 0, AW'(a), 0, AW'(a), AW'(NR - 1 - a), 0);

    // Bypass, persistence, x0 hardwired
    drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, 0);
    idle_read(5, 5);
    drive(0, 1, 0, 32'h1234, 0, 0, 0, 0, 5, 0);
    idle_read(0, 0);

    // Saturating scoreboard on x7
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 7, 0, 7, 0, 0);
    drive(0, 0, 0, 0, 1, 7, 0, 7, 7, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 7, 32'h700 + i, 0, 7, 0, 7, 7, 0);
    idle_read(7, 0);

    // Simultaneous issue and writeback, then flush
    drive(0, 0, 0, 0, 1, 9, 0, 9, 0, 0);
    drive(0, 1, 9, 32'h99, 1, 9, 0, 9, 9, 0);
    idle_read(9, 9);
    drive(0, 0, 0, 0, 1, 10, 0, 9, 10, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 9, 10, 0);
    for (int a = 0; a < NR; a += 2) idle_read(AW'(a), AW'(a + 1));

    // Reset in mid-stream
    drive(0, 1, 3, 32'hA5, 0, 0, 0, 3, 0, 0);
    drive(0, 0, 0, 0, 1, 3, 0, 3, 0, 0);
    drive(0, 0, 0, 0, 1, 3, 0, 3, 5, 0);
    drive(1, 0, 0, 0, 0, 3, 0, 3, 5, 0);
    idle_read(3, 5);

`ifdef MSRV32_RF_PARITY_EN
    drive(0, 1, 4, 32'h0F0F0F01, 0, 0, 0, 4, 0, 1);
    idle_read(4, 0);
    drive(0, 1, 4, 32'h0F0F0F01, 0, 0, 0, 4, 0, 0);
    idle_read(4, 4);
`endif

    // Random traffic; narrow address window most of the time to force collisions
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) begin
        ra = AW'($urandom_range(NR - 1)); rb = AW'($urandom_range(NR - 1));
        rw = AW'($urandom_range(NR - 1)); ri = AW'($urandom_range(NR - 1));
      end else begin
        ra = AW'($urandom_range(7)); rb = AW'($urandom_range(7));
        rw = AW'($urandom_range(7)); ri = AW'($urandom_range(7));
      end
      drive($urandom_range(99) == 0, 1'($urandom_range(1)), rw, $urandom,
            1'($urandom_range(2) != 0), ri, $urandom_range(19) == 0, ra, rb,
`ifdef MSRV32_RF_PARITY_EN
            1'($urandom_range(3) == 0)
`else
            1'b0
`endif
           );
    end

    t = 0;
    while (sb_q.size() > 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("sb_drain", -1, sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
